// File: rtl/magic_unwind_if.sv
// Stream bundle for magic_unwind: encoded input side, decoded output side and
// frame accounting results. The block uses the slave modport.
interface magic_unwind_if #(
  parameter int LEN_W = 16
) ();
  // Handshake rule on both sides: a beat transfers on the rising clock edge
  // where valid && ready; the sender holds payload stable while valid && !ready.
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [1:0]       in_op;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_lossy;
  logic             out_err;
  logic             out_last;
  logic             frame_done;
  logic [LEN_W-1:0] frame_len;
  logic [7:0]       frame_xor;

  modport slave (
    input  in_valid, in_data, in_op, in_last, out_ready,
    output in_ready, out_valid, out_data, out_lossy, out_err, out_last,
           frame_done, frame_len, frame_xor
  );

  modport master (
    output in_valid, in_data, in_op, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_lossy, out_err, out_last,
           frame_done, frame_len, frame_xor
  );
endinterface

// File: rtl/magic_unwind.sv
// Streaming inverse of the four-op flag byte transform with an output FIFO and
// per-frame length/XOR accounting. Define MAGIC_UNWIND_STRICT_EN to flag impossible op 01 inputs.
module magic_unwind #(
  parameter int DEPTH = 2,
  parameter int LEN_W = 16
) (
  input  logic clk,
  input  logic rst,
  magic_unwind_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Decode of the incoming byte
  logic [7:0] dec_data;
  logic       dec_lossy;
  logic       dec_err;

  always_comb begin
    dec_data  = 8'h00;
    dec_lossy = 1'b0;
    dec_err   = 1'b0;
    case (bus.in_op)
      2'b00: dec_data = {bus.in_data[2:0], bus.in_data[7:3]};
      2'b01: begin
        dec_data  = {bus.in_data[5:0] ^ 6'h1A, 2'b00};
        dec_lossy = 1'b1;
`ifdef MAGIC_UNWIND_STRICT_EN
        // Forward op 01 never produces nonzero top bits after un-XOR.
        if ((bus.in_data[7:6] ^ 2'b01) != 2'b00) begin
          dec_err  = 1'b1;
          dec_data = 8'h00;
        end
`endif
      end
      2'b10: dec_data = bus.in_data - 8'd77;
      default: dec_data = bus.in_data ^ 8'h33;
    endcase
  end

  // FIFO entry layout: {data[7:0], lossy, err, last}
  logic [10:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready_q;
  logic          push, pop, fifo_valid;
  logic [10:0]   head;

  assign fifo_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign push       = bus.in_valid && in_ready_q;
  assign pop        = fifo_valid && bus.out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {dec_data, dec_lossy, dec_err, bus.in_last};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      // Registered so ready never depends combinationally on out_ready.
      in_ready_q <= (count_d != FULL_CNT);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_valid ? head[10:3] : 8'h00;
  assign bus.out_lossy = fifo_valid & head[2];
  assign bus.out_err   = fifo_valid & head[1];
  assign bus.out_last  = fifo_valid & head[0];

  // Frame accounting on popped beats
  logic [LEN_W-1:0] len_q, len_inc, frame_len_q;
  logic [7:0]       xor_q, xor_nxt, frame_xor_q;
  logic             done_q;

  always_comb begin
    len_inc = (len_q == '1) ? len_q : len_q + LEN_W'(1);
    xor_nxt = head[1] ? xor_q : (xor_q ^ head[10:3]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q       <= '0;
      xor_q       <= 8'h00;
      frame_len_q <= '0;
      frame_xor_q <= 8'h00;
      done_q      <= 1'b0;
    end else begin
      done_q <= pop && head[0];
      if (pop) begin
        if (head[0]) begin
          frame_len_q <= len_inc;
          frame_xor_q <= xor_nxt;
          len_q       <= '0;
          xor_q       <= 8'h00;
        end else begin
          len_q <= len_inc;
          xor_q <= xor_nxt;
        end
      end
    end
  end

  assign bus.frame_done = done_q;
  assign bus.frame_len  = frame_len_q;
  assign bus.frame_xor  = frame_xor_q;
endmodule

// File: tb/tb_magic_unwind.sv
// Directed bench for magic_unwind: a driver pushes hand-computed expectations
// into queues; negedge monitors pop and compare output beats and frame results.
module tb_magic_unwind;
  localparam int LEN_W = 16;
  localparam int DEPTH = 2;
  localparam int N_FRAMES = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  magic_unwind_if #(.LEN_W(LEN_W)) bus ();

  magic_unwind #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  logic [10:0]        exp_q[$];
  logic [LEN_W+7:0]   exp_frame_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Output beat monitor
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h with no expected beat queued", bus.out_data);
      end else begin
        chk("out_beat", {bus.out_data, bus.out_lossy, bus.out_err, bus.out_last}, exp_q.pop_front());
      end
    end
  end

  // Frame result monitor
  always @(negedge clk) begin
    if (rst && bus.frame_done) begin
      done_seen++;
      if (exp_frame_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got len %0d xor 0x%0h", bus.frame_len, bus.frame_xor);
      end else begin
        chk("frame_len_xor", {bus.frame_len, bus.frame_xor}, exp_frame_q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [1:0] op, input logic last,
                      input logic [7:0] exp_d, input logic exp_lossy, input logic exp_err);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_op    = op;
    bus.in_last  = last;
    while (!acc && n < 200) begin
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (acc) exp_q.push_back({exp_d, exp_lossy, exp_err, last});
    else chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_frame(input logic [LEN_W-1:0] len, input logic [7:0] x);
    exp_frame_q.push_back({len, x});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_frame_q.size() != 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("drain_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  logic [7:0] sb_din [4] = '{8'h0B, 8'h8E, 8'h55, 8'h44};
  logic [1:0] sb_op  [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [7:0] sb_exp [4] = '{8'h61, 8'h41, 8'h66, 8'h78};
  logic       sb_lsy [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_op     = 2'b00;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset values
    #22;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_flags", {bus.out_data, bus.out_lossy, bus.out_err, bus.out_last}, 0);
    chk("rst_frame", {bus.frame_done, bus.frame_len, bus.frame_xor}, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", bus.in_ready, 1);

    // Single beats with one-cycle latency
    for (int i = 0; i < 4; i++) begin
      push_frame(16'd1, sb_exp[i]);
      send(sb_din[i], sb_op[i], 1'b1, sb_exp[i], sb_lsy[i], 1'b0);
      chk("lat_valid", bus.out_valid, 1);
      chk("lat_data", bus.out_data, {24'd0, sb_exp[i]});
      repeat (2) @(posedge clk);
      #1;
    end

    // Out-of-range op 01 input
`ifdef MAGIC_UNWIND_STRICT_EN
    push_frame(16'd1, 8'h00);
    send(8'hFF, 2'b01, 1'b1, 8'h00, 1'b1, 1'b1);
`else
    push_frame(16'd1, 8'h94);
    send(8'hFF, 2'b01, 1'b1, 8'h94, 1'b1, 1'b0);
`endif
    drain();

    // Three-beat frame, back-to-back
    push_frame(16'd3, 8'h46);
    send(8'h0B, 2'b00, 1'b0, 8'h61, 1'b0, 1'b0);
    send(8'h8E, 2'b10, 1'b0, 8'h41, 1'b0, 1'b0);
    send(8'h55, 2'b11, 1'b1, 8'h66, 1'b0, 1'b0);
    drain();
    chk("frame3_len_hold", bus.frame_len, 3);

    // Subtract wrap, then a frame whose checksum is zero
    push_frame(16'd1, 8'hB3);
    send(8'h00, 2'b10, 1'b1, 8'hB3, 1'b0, 1'b0);
    push_frame(16'd1, 8'h00);
    send(8'h4D, 2'b10, 1'b1, 8'h00, 1'b0, 1'b0);
    drain();
    chk("wrap_frame_len", bus.frame_len, 1);

    // Backpressure with a full FIFO
    bus.out_ready = 1'b0;
    push_frame(16'd3, 8'h46);
    send(8'h0B, 2'b00, 1'b0, 8'h61, 1'b0, 1'b0);
    send(8'h55, 2'b11, 1'b0, 8'h66, 1'b0, 1'b0);
    chk("full_in_ready", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_data", {bus.out_valid, bus.out_data}, {1'b1, 8'h61});
      @(posedge clk);
      #1;
    end
    fork
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      send(8'h8E, 2'b10, 1'b1, 8'h41, 1'b0, 1'b0);
    join
    drain();
    chk("bp_frame_len", bus.frame_len, 3);

    // Reset in the middle of a frame
    bus.out_ready = 1'b0;
    send(8'h0B, 2'b00, 1'b0, 8'h61, 1'b0, 1'b0);
    send(8'h8E, 2'b10, 1'b0, 8'h41, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_frame", {bus.frame_len, bus.frame_xor}, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    push_frame(16'd1, 8'h66);
    send(8'h55, 2'b11, 1'b1, 8'h66, 1'b0, 1'b0);
    drain();
    chk("postrst_frame_len", bus.frame_len, 1);

    chk("exp_q_empty", exp_q.size(), 0);
    chk("frames_seen", done_seen, N_FRAMES);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/magic_unwind.md
Name: magic_unwind

Overview:
- Streaming inverse of the four-op byte transform used by the flag checker.
- Accepts encoded bytes tagged with the same 2-bit op selector and emits the recovered plaintext bytes.
- Each beat passes through a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Tracks per-frame length and XOR checksum, so the checker back-end can compare a decoded flag frame against the expected value without software replay.

Parameters:
DEPTH, 2, output FIFO entries; power of two, minimum 2
LEN_W, 16, width of frame byte counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low
in_valid  input  1  encoded byte present
in_ready  output  1  block can accept a beat
in_data  input  8  encoded byte
in_op  input  2  op selector the byte was encoded with
in_last  input  1  final byte of frame
out_valid  output  1  decoded byte present
out_ready  input  1  downstream accepts beat
out_data  output  8  decoded byte
out_lossy  output  1  op 01 beat; bits [1:0] unrecoverable, forced 0
out_err  output  1  op 01 encoded value out of range (strict mode only)
out_last  output  1  final byte of frame
frame_done  output  1  one-cycle pulse when out_last beat transfers
frame_len  output  LEN_W  byte count of last completed frame
frame_xor  output  8  XOR of out_data over last completed frame

Behaviour:
- Reset (rst=0, async) clears FIFO, counters and flags. Reset values: in_ready=0 while rst=0, then 1 from the first cycle after release. out_valid=0, out_data=0, out_lossy=0, out_err=0, out_last=0, frame_done=0, frame_len=0, frame_xor=0.
- Reset mid-frame discards all queued beats and the partial frame; no frame_done pulse is generated.
- Decode is combinational on the input side; the result is written into the FIFO on in_valid&&in_ready:
  op 00: rotate right by 3, {y[2:0],y[7:3]}.
  op 01: t=y^8'h5A; out={t[5:0],2'b00}; out_lossy=1.
  op 10: y-8'd77, mod 256 (wraps, e.g. 0x00 -> 0xB3).
  op 11: y^8'h33.
  out_lossy=0 for ops 00/10/11.
- FIFO entry stores {data, lossy, err, last}.
- in_ready = FIFO not full, driven from registered occupancy only, with no combinational path from out_ready.
- When the FIFO is full, in_ready=0, even if a pop occurs in the same cycle.
- Latency: a beat accepted at edge N is visible on out_valid/out_data after edge N, provided the FIFO was empty.
- Output handshake: the head entry holds stable while out_valid=1 and out_ready=0. It pops on out_valid&&out_ready.
- Simultaneous push and pop when not full: occupancy is unchanged and order is preserved.
- Frame accounting runs on the output side:
  - Each popped beat increments the running count, saturating at all-ones, and XORs out_data into the running checksum.
  - On a popped beat with out_last=1, the cycle after the pop: frame_len=count including that beat, frame_xor=checksum including it, frame_done pulses for 1 cycle, and the running accumulators clear.
  - frame_len/frame_xor hold until the next frame_done.
- Back-to-back frames are supported: a beat following a last beat starts a new frame with no idle cycle.

Optional Feature:
Macro MAGIC_UNWIND_STRICT_EN.
- Defined: an op 01 beat with (y^8'h5A)[7:6]!=2'b00 cannot have come from the forward transform. It is still emitted, with out_err=1, out_data=8'h00 and out_lossy=1. It counts toward frame_len, and frame_xor is unchanged by it.
- Undefined: no range check; out_err is tied to 0; decode is as above with upper bits truncated.

Test Plan:
- Single beats, FIFO empty, out_ready=1:
  0x0B/op00 -> out 0x61.
  0x8E/op10 -> out 0x41.
  0x55/op11 -> out 0x66.
  0x44/op01 -> out 0x78 with out_lossy=1.
  Each appears 1 cycle after acceptance.
- Frame 0x0B/00, 0x8E/10, 0x55/11 (last), out_ready=1 -> out_last only on the 3rd beat; frame_done pulses once; frame_len=3; frame_xor=0x46.
- Wrap check: 0x00/op10 -> 0xB3. Next frame 0x4D/op10 (last) -> 0x00, frame_len=1, frame_xor=0x00.
- Backpressure: out_ready=0, push 3 beats with DEPTH=2 -> in_ready drops after 2 accepts; out_data stable. Raise out_ready -> all 3 beats emerge in order, none lost or duplicated.
- Reset mid-frame: after 2 of 3 beats are accepted, pulse rst low -> out_valid=0 and frame_len=0 immediately; no frame_done; a following 1-beat frame reports frame_len=1.
- Strict build: 0xFF/op01 -> out_err=1, out_data=0x00. Non-strict build: same input -> out_data=0x94, out_err=0.
